// File: rtl/image_wr_arb_pkg.sv
// Shared types and constants for the image write-port arbiter.
package image_wr_arb_pkg;

   localparam int unsigned DEF_NUM_REQ   = 3;
   localparam int unsigned DEF_ADDR_W    = 29;
   localparam int unsigned DEF_DATA_W    = 128;
   localparam int unsigned DEF_CNT_W     = 9;
   localparam int unsigned DEF_BURST_LEN = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/image_wr_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: first set req bit at index >= ptr, wrapping.
module rr_arb_pick
   import image_wr_arb_pkg::*;
#(
   parameter  int unsigned N  = DEF_NUM_REQ,
   localparam int unsigned PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic          valid
);

   logic [2*N-1:0] rot;
   logic [2*N-1:0] shl;
   logic [N-1:0]   oh;

   // Rotate so ptr sits at bit 0, take lowest set bit, rotate the one-hot back.
   always_comb begin
      valid = 1'b0;
      oh    = '0;
      rot   = {req, req} >> ptr;
      for (int i = 0; i < int'(N); i++) begin
         if (!valid && rot[i]) begin
            oh[i] = 1'b1;
            valid = 1'b1;
         end
      end
      shl  = {{N{1'b0}}, oh} << ptr;
      pick = shl[N-1:0] | shl[2*N-1:N];
   end

endmodule

// File: rtl/image_wr_arbiter.sv
// Round-robin arbiter sharing one MIG write port between NUM_REQ image writers.
// Optional per-requester completion counters under IMAGE_WR_ARB_STATS_EN.
module image_wr_arbiter
   import image_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
   input  logic                      mem_clk,
   input  logic                      mem_reset,
   input  logic [NUM_REQ-1:0]        req_wr_req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_wr_addr,
   input  logic [NUM_REQ*CNT_W-1:0]  req_rd_count,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdf_data,
   output logic [NUM_REQ-1:0]        req_wr_ack,
   output logic [NUM_REQ-1:0]        req_rd_en,
   output logic                      mem_wr_req,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   input  logic                      mem_wr_ack,
   input  logic                      mem_wdata_rd_en,
   output logic [DATA_W-1:0]         mem_wdf_data,
   output logic [CNT_W-1:0]          fifo_rd_data_count,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      proto_err
`ifdef IMAGE_WR_ARB_STATS_EN
  ,output logic [NUM_REQ*32-1:0]     grant_count
`endif
);

   localparam int unsigned PW = clog2(NUM_REQ);
   localparam int unsigned BW = clog2(BURST_LEN + 1);

   state_t             state, state_d;
   logic [NUM_REQ-1:0] grant_d;
   logic               mem_wr_req_d;
   logic [PW-1:0]      rr_ptr, rr_ptr_d;
   logic [BW-1:0]      beat_cnt, beat_cnt_d, beat_cnt_inc;
   logic               ack_seen, ack_seen_d;
   logic               proto_err_d;

   logic [NUM_REQ-1:0] pick;
   logic               pick_valid;
   logic [PW-1:0]      gidx;
   logic [DATA_W-1:0]  mux_data;
   logic               beat_room, beat_ok, beat_err, ack_ok, ack_err, done;

   rr_arb_pick #(.N(NUM_REQ)) u_pick (
      .req   (req_wr_req),
      .ptr   (rr_ptr),
      .pick  (pick),
      .valid (pick_valid)
   );

   // Index of the granted requester and grant-steered muxes.
   always_comb begin
      gidx               = '0;
      mem_wr_addr        = '0;
      mux_data           = '0;
      fifo_rd_data_count = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (grant[k]) begin
            gidx               = PW'(k);
            mem_wr_addr        = req_wr_addr[k*ADDR_W +: ADDR_W];
            mux_data           = req_wdf_data[k*DATA_W +: DATA_W];
            fifo_rd_data_count = req_rd_count[k*CNT_W +: CNT_W];
         end
      end
   end

   // Beat/ack qualification, strobes back to the granted requester, completion.
   always_comb begin
      beat_room    = (grant != '0) && (beat_cnt < BW'(BURST_LEN));
      beat_ok      = mem_wdata_rd_en && beat_room;
      beat_err     = mem_wdata_rd_en && !beat_room;
      ack_ok       = mem_wr_ack && (state == ADDR);
      ack_err      = mem_wr_ack && (state != ADDR);
      req_rd_en    = beat_ok ? grant : '0;
      req_wr_ack   = ack_ok ? grant : '0;
      mem_wdf_data = beat_err ? '0 : mux_data;
      beat_cnt_inc = beat_ok ? beat_cnt + BW'(1) : beat_cnt;
      done         = (state != IDLE) && (ack_seen || ack_ok) &&
                     (beat_cnt_inc == BW'(BURST_LEN));
   end

   // Next-state and next-register values.
   always_comb begin
      state_d      = state;
      grant_d      = grant;
      mem_wr_req_d = mem_wr_req;
      rr_ptr_d     = rr_ptr;
      beat_cnt_d   = beat_cnt_inc;
      ack_seen_d   = ack_seen;
      proto_err_d  = proto_err | beat_err | ack_err;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_d      = pick;
               mem_wr_req_d = 1'b1;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            if (ack_ok) begin
               mem_wr_req_d = 1'b0;
               ack_seen_d   = 1'b1;
               state_d      = DATA;
            end
         end
         DATA: ;
         default: state_d = IDLE;
      endcase
      if (done) begin
         state_d      = IDLE;
         grant_d      = '0;
         mem_wr_req_d = 1'b0;
         beat_cnt_d   = '0;
         ack_seen_d   = 1'b0;
         rr_ptr_d     = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
      end
   end

   // State and control registers.
   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         state      <= IDLE;
         grant      <= '0;
         mem_wr_req <= 1'b0;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         ack_seen   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         mem_wr_req <= mem_wr_req_d;
         rr_ptr     <= rr_ptr_d;
         beat_cnt   <= beat_cnt_d;
         ack_seen   <= ack_seen_d;
         proto_err  <= proto_err_d;
      end
   end

`ifdef IMAGE_WR_ARB_STATS_EN
   // Per-requester completed-transfer counters, wrapping at 2^32.
   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         grant_count <= '0;
      end else begin
         for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (done && grant[k]) grant_count[k*32 +: 32] <= grant_count[k*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule
